// File: rtl/psram_qspi_responder.sv
// QSPI PSRAM device model: oversamples the controller's sck/ce_n/dio with clk and serves
// quad read (0xEB) / quad write (0x38) from an internal byte array. Optional QPI mode via PSRAM_QPI_EN.
module psram_qspi_responder #(
  parameter int unsigned MEM_AW    = 12,
  parameter int unsigned DUMMY_CYC = 6
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       qspi_sck,
  input  logic       qspi_ce_n,
  input  logic [3:0] qspi_din,
  output logic [3:0] qspi_dout,
  output logic [3:0] qspi_douten
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RDATA,
    WDATA,
    IGNORE
  } state_t;

  state_t            state;
  logic [2:0]        sck_sync;
  logic [1:0]        ce_sync;
  logic [3:0]        din_m;
  logic [3:0]        din_s;
  logic              rise;
  logic              fall;
  logic              ce_s;
  logic [6:0]        cmd_sr;
  logic [7:0]        cmd_nxt;
  logic              cmd_last;
  logic [7:0]        cnt;
  logic              is_rd;
  logic              nib_lo;
  logic [3:0]        hi_nib;
  logic [MEM_AW-1:0] ptr;
  logic [MEM_AW-1:0] ptr_shift;
  logic              mem_we;
  logic              qpi_mode;
  logic [7:0]        mem [0:(1<<MEM_AW)-1];

  // ce_n synchronizer idles high so a reset release never looks like a select
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sck_sync <= '0;
      ce_sync  <= '1;
      din_m    <= '0;
      din_s    <= '0;
    end else begin
      sck_sync <= {sck_sync[1:0], qspi_sck};
      ce_sync  <= {ce_sync[0], qspi_ce_n};
      din_m    <= qspi_din;
      din_s    <= din_m;
    end
  end

  assign rise = sck_sync[1] & ~sck_sync[2];
  assign fall = ~sck_sync[1] & sck_sync[2];
  assign ce_s = ce_sync[1];

  // Shifting nibbles into a MEM_AW-wide pointer keeps only the low address bits (wrap/alias)
  always_comb begin
    ptr_shift = (ptr << 4) | MEM_AW'(din_s);
    cmd_nxt   = qpi_mode ? {cmd_sr[3:0], din_s} : {cmd_sr, din_s[0]};
    cmd_last  = qpi_mode ? (cnt == 8'd1) : (cnt == 8'd7);
    mem_we    = (state == WDATA) && rise && !ce_s && nib_lo;
  end

`ifndef PSRAM_QPI_EN
  assign qpi_mode = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr] <= {hi_nib, din_s};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      qspi_dout   <= '0;
      qspi_douten <= '0;
      cmd_sr      <= '0;
      cnt         <= '0;
      is_rd       <= 1'b0;
      nib_lo      <= 1'b0;
      hi_nib      <= '0;
      ptr         <= '0;
`ifdef PSRAM_QPI_EN
      qpi_mode    <= 1'b0;
`endif
    end else if (ce_s) begin
      state       <= IDLE;
      qspi_dout   <= '0;
      qspi_douten <= '0;
    end else begin
      case (state)
        IDLE: begin
          state  <= CMD;
          cnt    <= '0;
          cmd_sr <= '0;
        end
        CMD: if (rise) begin
          cmd_sr <= cmd_nxt[6:0];
          cnt    <= cnt + 8'd1;
          if (cmd_last) begin
            cnt <= '0;
            ptr <= '0;
            if (cmd_nxt == 8'hEB) begin
              state <= ADDR;
              is_rd <= 1'b1;
            end else if (cmd_nxt == 8'h38) begin
              state <= ADDR;
              is_rd <= 1'b0;
            end
`ifdef PSRAM_QPI_EN
            else if (cmd_nxt == 8'h35) begin
              qpi_mode <= 1'b1;
              state    <= IGNORE;
            end else if (cmd_nxt == 8'hF5) begin
              qpi_mode <= 1'b0;
              state    <= IGNORE;
            end
`endif
            else begin
              state <= IGNORE;
            end
          end
        end
        ADDR: if (rise) begin
          ptr <= ptr_shift;
          cnt <= cnt + 8'd1;
          if (cnt == 8'd5) begin
            cnt    <= '0;
            nib_lo <= 1'b0;
            state  <= is_rd ? DUMMY : WDATA;
          end
        end
        // cnt counts dummy rises; the first fall after the last one launches data
        DUMMY: begin
          if (rise) begin
            cnt <= cnt + 8'd1;
          end else if (fall && cnt == 8'(DUMMY_CYC)) begin
            qspi_douten <= 4'hF;
            qspi_dout   <= mem[ptr][7:4];
            nib_lo      <= 1'b1;
            state       <= RDATA;
          end
        end
        RDATA: if (fall) begin
          if (nib_lo) begin
            qspi_dout <= mem[ptr][3:0];
            ptr       <= ptr + MEM_AW'(1);
            nib_lo    <= 1'b0;
          end else begin
            qspi_dout <= mem[ptr][7:4];
            nib_lo    <= 1'b1;
          end
        end
        WDATA: if (rise) begin
          if (nib_lo) begin
            ptr    <= ptr + MEM_AW'(1);
            nib_lo <= 1'b0;
          end else begin
            hi_nib <= din_s;
            nib_lo <= 1'b1;
          end
        end
        IGNORE: begin
          qspi_douten <= '0;
        end
        default: begin
          state       <= IDLE;
          qspi_douten <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psram_qspi_responder.sv
// Bus-level bench for psram_qspi_responder: drives QSPI transactions at sck = clk/8 from a vector table.
module tb_psram_qspi_responder;
  localparam int unsigned MEM_AW    = 12;
  localparam int unsigned DUMMY_CYC = 6;

  logic       clk = 1'b0;
  logic       resetn;
  logic       sck;
  logic       ce_n;
  logic [3:0] din;
  logic [3:0] dout;
  logic [3:0] douten;

  psram_qspi_responder #(.MEM_AW(MEM_AW), .DUMMY_CYC(DUMMY_CYC)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .qspi_sck    (sck),
    .qspi_ce_n   (ce_n),
    .qspi_din    (din),
    .qspi_dout   (dout),
    .qspi_douten (douten)
  );

  always #5 clk = ~clk;

  typedef enum int {K_WR, K_RD, K_NONE} kind_t;
  typedef struct {
    logic [7:0]  cmd;
    bit          quad;
    logic [23:0] addr;
    kind_t       kind;
    int unsigned nnib;
    logic [15:0] data;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  function automatic vec_t mk(input logic [7:0] c, input bit qd, input logic [23:0] a,
                              input kind_t k, input int unsigned n, input logic [15:0] d);
    vec_t v;
    v.cmd = c; v.quad = qd; v.addr = a; v.kind = k; v.nnib = n; v.data = d;
    return v;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // one sck period: fall with new din, sample dout just before the rise
  task automatic cyc(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
    sck = 1'b0;
    din = d;
    repeat (4) @(negedge clk);
    q   = dout;
    oe  = douten;
    sck = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] c, input bit quad);
    logic [3:0] q, oe;
    if (quad) begin
      cyc(c[7:4], q, oe); check("cmd_oe", oe, 4'h0);
      cyc(c[3:0], q, oe); check("cmd_oe", oe, 4'h0);
    end else begin
      for (int i = 7; i >= 0; i--) begin
        cyc({3'b000, c[i]}, q, oe);
        check("cmd_oe", oe, 4'h0);
      end
    end
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [3:0] q, oe;
    for (int i = 5; i >= 0; i--) begin
      cyc(a[i*4 +: 4], q, oe);
      check("addr_oe", oe, 4'h0);
    end
  endtask

  task automatic xfer(input vec_t v);
    logic [3:0] q, oe, d;
    ce_n = 1'b0;
    repeat (4) @(negedge clk);
    send_cmd(v.cmd, v.quad);
    case (v.kind)
      K_NONE: begin
        for (int i = 0; i < int'(v.nnib); i++) begin
          d = 4'h0;
          if (i < 6) d = v.addr[(5-i)*4 +: 4];
          cyc(d, q, oe);
          check("ign_oe", oe, 4'h0);
        end
      end
      K_WR: begin
        send_addr(v.addr);
        for (int i = 0; i < int'(v.nnib); i++) begin
          cyc(v.data[15-4*i -: 4], q, oe);
          check("wr_oe", oe, 4'h0);
        end
      end
      default: begin
        send_addr(v.addr);
        for (int i = 0; i < int'(DUMMY_CYC); i++) begin
          cyc(4'h0, q, oe);
          check("dummy_oe", oe, 4'h0);
        end
        for (int i = 0; i < int'(v.nnib); i++) exp_q.push_back(v.data[15-4*i -: 4]);
        for (int i = 0; i < int'(v.nnib); i++) begin
          cyc(4'h0, q, oe);
          check("rd_oe", oe, 4'hF);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_queue got empty want entry");
          end else begin
            check("rd_data", q, exp_q.pop_front());
          end
        end
      end
    endcase
    sck = 1'b0;
    repeat (4) @(negedge clk);
    ce_n = 1'b1;
    repeat (8) @(negedge clk);
    check("idle_oe", douten, 4'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] q, oe;
    resetn = 1'b0;
    sck    = 1'b0;
    ce_n   = 1'b1;
    din    = 4'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sck  = ~sck;
      ce_n = (i % 2) == 1;
      din  = 4'(i);
      repeat (2) @(negedge clk);
      check("rst_oe", douten, 4'h0);
      check("rst_dout", dout, 4'h0);
    end
    sck  = 1'b0;
    ce_n = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_oe", douten, 4'h0);

    tbl.push_back(mk(8'h38, 1'b0, 24'h000010, K_WR,   4,  16'hA53C));
    tbl.push_back(mk(8'hEB, 1'b0, 24'h000010, K_RD,   4,  16'hA53C));
    tbl.push_back(mk(8'h38, 1'b0, 24'h000FFF, K_WR,   4,  16'h1122));
    tbl.push_back(mk(8'hEB, 1'b0, 24'h000FFF, K_RD,   2,  16'h1100));
    tbl.push_back(mk(8'hEB, 1'b0, 24'h000000, K_RD,   2,  16'h2200));
    tbl.push_back(mk(8'hEB, 1'b0, 24'hABC000, K_RD,   2,  16'h2200));
    tbl.push_back(mk(8'hEB, 1'b0, 24'h000FFF, K_RD,   4,  16'h1122));
    tbl.push_back(mk(8'h38, 1'b0, 24'h000021, K_WR,   2,  16'h7700));
    tbl.push_back(mk(8'h38, 1'b0, 24'h000020, K_WR,   3,  16'h1230));
    tbl.push_back(mk(8'hEB, 1'b0, 24'h000020, K_RD,   4,  16'h1277));
    tbl.push_back(mk(8'h9F, 1'b0, 24'h000000, K_NONE, 14, 16'h0000));
    tbl.push_back(mk(8'hEB, 1'b0, 24'h000010, K_RD,   4,  16'hA53C));
`ifdef PSRAM_QPI_EN
    tbl.push_back(mk(8'h35, 1'b0, 24'h000000, K_NONE, 0,  16'h0000));
    tbl.push_back(mk(8'hEB, 1'b1, 24'h000010, K_RD,   2,  16'hA500));
    tbl.push_back(mk(8'hF5, 1'b1, 24'h000000, K_NONE, 0,  16'h0000));
    tbl.push_back(mk(8'hEB, 1'b0, 24'h000010, K_RD,   2,  16'hA500));
`else
    tbl.push_back(mk(8'h35, 1'b0, 24'h000000, K_NONE, 0,  16'h0000));
    tbl.push_back(mk(8'hEB, 1'b1, 24'h000010, K_NONE, 14, 16'h0000));
    tbl.push_back(mk(8'hEB, 1'b0, 24'h000010, K_RD,   2,  16'hA500));
`endif
    for (int i = 0; i < tbl.size(); i++) xfer(tbl[i]);

    // reset while driving read data: outputs drop at once, memory survives
    ce_n = 1'b0;
    repeat (4) @(negedge clk);
    send_cmd(8'hEB, 1'b0);
    send_addr(24'h000010);
    for (int i = 0; i < int'(DUMMY_CYC); i++) cyc(4'h0, q, oe);
    cyc(4'h0, q, oe);
    check("mr_data", q, 4'hA);
    check("mr_oe", oe, 4'hF);
    resetn = 1'b0;
    #1;
    check("mr_rst_oe", douten, 4'h0);
    check("mr_rst_dout", dout, 4'h0);
    sck  = 1'b0;
    ce_n = 1'b1;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    xfer(mk(8'hEB, 1'b0, 24'h000010, K_RD, 4, 16'hA53C));

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
